// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encoding (also used by alu_decoder) and
// the execute-stage state encoding.
package alu_pkg;

  // ALUControl codes produced by the decode stage.
  typedef enum logic [2:0] {
    ALU_SUB = 3'b000,
    ALU_MUL = 3'b001,
    ALU_OR  = 3'b010,
    ALU_SLL = 3'b011,
    ALU_LT  = 3'b100,
    ALU_GE  = 3'b101,
    ALU_CMP = 3'b110,
    ALU_ADD = 3'b111
  } alu_op_e;

  // Execute-stage control states. MUL and HOLD are only reachable when the
  // iterative multiplier is built.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } exec_state_e;

  // True for the one opcode that may take more than a single cycle.
  function automatic logic is_mul_op(input logic [2:0] code);
    return code == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Handshake bundle between the decode stage (master) and the execute stage
// (slave): request side carries ALUControl + operands, response side carries
// the result, its flags and the multiplier busy indication.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_neg;
  logic             busy;

  // Decode-stage / testbench view.
  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_neg, busy
  );

  // Execute-stage view.
  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_neg, busy
  );
endinterface

// File: rtl/alu_seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles
// per product. Produces the low WIDTH bits of the unsigned product.
// 'done' and 'product' are valid together in the final iteration cycle so the
// owner can capture the product on the same edge the last bit is consumed.
module alu_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  // Partial-product add for the multiplier bit consumed this cycle.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign done     = running && (cnt == LAST_CNT);

  // Sequencing: iteration counter and run flag; reset aborts any product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      // NOTE: non-blocking assignments in clocked blocks, so every register
      // here sees the pre-edge value of its neighbours regardless of order.
      if (done) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Datapath: load operands on start, then shift one bit per cycle.
  // NOTE: datapath registers carry no reset; they are always loaded by start
  // before being observed, and 'running' gates every use of them.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= multiplicand;
      mplier <= multiplier;
      acc    <= '0;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage. Single-cycle SUB/OR/SLL/LT/GE/CMP/ADD; MUL runs on the
// iterative alu_seq_mult core (latency WIDTH+1) unless ALU_FAST_MUL_EN is
// defined, in which case MUL is a single-cycle combinational multiply and the
// MUL/HOLD states are never entered.
// Result and flags sit in one output register that is held stable until the
// downstream handshake retires it.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_exec_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);

  exec_state_e      state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q;
  logic             flag_zero_q;
  logic             flag_neg_q;

  logic             accept;
  logic             is_iter_mul;
  logic             load_res;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] diff;
  logic             lt_s;
  logic [SHW-1:0]   shamt;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // New work is taken only from IDLE, and only when the output register is
  // free or being emptied this very cycle.
  assign bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign diff  = bus.op_a - bus.op_b;
  assign lt_s  = $signed(bus.op_a) < $signed(bus.op_b);
  assign shamt = bus.op_b[SHW-1:0];

`ifdef ALU_FAST_MUL_EN
  assign is_iter_mul = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign bus.busy    = 1'b0;
`else
  logic mul_start;

  assign is_iter_mul = is_mul_op(bus.alu_ctrl);
  assign mul_start   = accept && is_iter_mul;
  assign bus.busy    = (state_q == ST_MUL);

  alu_seq_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .multiplicand (bus.op_a),
    .multiplier   (bus.op_b),
    .done         (mul_done),
    .product      (mul_product)
  );
`endif

  // Single-cycle operation results selected by ALUControl.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it
    // unassigned and a latch cannot be inferred.
    alu_res = '0;
    case (alu_op_e'(bus.alu_ctrl))
      ALU_SUB, ALU_CMP: alu_res = diff;
`ifdef ALU_FAST_MUL_EN
      ALU_MUL:          alu_res = bus.op_a * bus.op_b;
`endif
      ALU_OR:           alu_res = bus.op_a | bus.op_b;
      ALU_SLL:          alu_res = bus.op_a << shamt;
      ALU_LT:           alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_GE:           alu_res = {{(WIDTH-1){1'b0}}, !lt_s};
      ALU_ADD:          alu_res = bus.op_a + bus.op_b;
      default:          alu_res = '0;
    endcase
  end

  // Next-state, output-valid and result-load decisions.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    load_res    = 1'b0;
    res_d       = alu_res;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_iter_mul) begin
            // Any held result retires on this same edge (accept implies it).
            state_d     = ST_MUL;
            out_valid_d = 1'b0;
          end else begin
            load_res    = 1'b1;
            out_valid_d = 1'b1;
          end
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          load_res    = 1'b1;
          res_d       = mul_product;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control state and the output register; flags are captured alongside the
  // result so they always describe the value on 'result'.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      if (load_res) begin
        result_q    <= res_d;
        flag_zero_q <= (res_d == '0);
        flag_neg_q  <= res_d[WIDTH-1];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_zero = flag_zero_q;
  assign bus.flag_neg  = flag_neg_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed corner cases followed by
// randomized traffic, all checked against a one-slot transaction model that
// predicts when each result becomes visible and what it must be.
module tb_alu_exec_stage;

  localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_GE  = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_ADD = 3'b111;

  logic clk = 1'b0;
  logic rst_n;

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Model: at most one result in flight, visible from cycle rdy_cyc onward.
  int           cyc       = 0;
  bit           full      = 1'b0;
  bit           slot_iter = 1'b0;
  int           rdy_cyc   = 0;
  logic [W-1:0] slot_res  = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint to_signed(input logic [W-1:0] v);
    longint u;
    u = longint'(v);
    return v[W-1] ? u - (longint'(1) << W) : u;
  endfunction

  // Reference arithmetic straight from the opcode table.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      OP_SUB, OP_CMP: r = a - b;
      OP_MUL:         r = a * b;
      OP_OR:          r = a | b;
      OP_SLL:         r = a << (b % W);
      OP_LT:          r = (to_signed(a) <  to_signed(b)) ? 1 : 0;
      OP_GE:          r = (to_signed(a) >= to_signed(b)) ? 1 : 0;
      default:        r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 1;
      2:       return '1;
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return {1'b1, {(W-1){1'b0}}};
      default: return $urandom();
    endcase
  endfunction

  // One clock cycle: drive inputs, compare outputs mid-cycle against the
  // model, update the model with this cycle's handshakes, then step.
  task automatic cycle(input bit iv, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit ordy);
    bit vis, exp_ir, exp_busy;
    bus.in_valid  = iv;
    bus.alu_ctrl  = op;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.out_ready = ordy;
    @(negedge clk);
    vis      = full && (cyc >= rdy_cyc);
    exp_ir   = !full || (vis && ordy && !slot_iter);
    exp_busy = full && !vis && slot_iter;
    check("out_valid", W'(bus.out_valid), W'(vis));
    check("in_ready",  W'(bus.in_ready),  W'(exp_ir));
    check("busy",      W'(bus.busy),      W'(exp_busy));
    if (vis) begin
      check("result",    bus.result,          slot_res);
      check("flag_zero", W'(bus.flag_zero),   W'(slot_res == '0));
      check("flag_neg",  W'(bus.flag_neg),    W'(slot_res[W-1]));
      if (ordy) full = 1'b0;
    end
    if (iv && exp_ir) begin
      full      = 1'b1;
      slot_res  = ref_alu(op, a, b);
      slot_iter = (op == OP_MUL) && (MUL_LAT > 1);
      rdy_cyc   = cyc + ((op == OP_MUL) ? MUL_LAT : 1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, OP_ADD, rnd_opnd(), rnd_opnd(), ordy);
  endtask

  // One-edge synchronous reset followed by a check of the reset state.
  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    full  = 1'b0;
    #2;
    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_busy",      W'(bus.busy),      '0);
    check("rst_result",    bus.result,        '0);
    check("rst_flag_zero", W'(bus.flag_zero), '0);
    check("rst_flag_neg",  W'(bus.flag_neg),  '0);
    check("rst_in_ready",  W'(bus.in_ready),  W'(1));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = OP_ADD;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    do_reset();

    // Signed-overflow ADD wraps into the sign bit.
    cycle(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    check("add_wrap", bus.result, 32'h8000_0000);
    check("add_neg",  W'(bus.flag_neg),  W'(1));
    check("add_nz",   W'(bus.flag_zero), '0);

    // Equal operands give zero; signed compares treat -1 as less than 1.
    cycle(1'b1, OP_SUB, 32'd5, 32'd5, 1'b1);
    check("sub_zero", W'(bus.flag_zero), W'(1));
    cycle(1'b1, OP_CMP, 32'd5, 32'd5, 1'b1);
    check("cmp_zero", W'(bus.flag_zero), W'(1));
    cycle(1'b1, OP_LT, 32'hFFFF_FFFF, 32'd1, 1'b1);
    check("lt_signed", bus.result, 32'd1);
    cycle(1'b1, OP_GE, 32'hFFFF_FFFF, 32'd1, 1'b1);
    check("ge_signed", bus.result, 32'd0);

    // Iterative multiply: result appears WIDTH+1 cycles after accept.
    cycle(1'b1, OP_MUL, 32'd1234, 32'd5678, 1'b1);
    for (int i = 0; i < MUL_LAT - 1; i++) cycle(1'b1, OP_OR, rnd_opnd(), rnd_opnd(), 1'b0);
    check("mul_valid", W'(bus.out_valid), W'(1));
    check("mul_val",   bus.result, 32'd7006652);
    idle(2, 1'b1);

    // Back-to-back ORs, then a 3-cycle downstream stall with input pending.
    for (int i = 0; i < 4; i++) cycle(1'b1, OP_OR, rnd_opnd(), rnd_opnd(), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, OP_OR, rnd_opnd(), rnd_opnd(), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, OP_OR, rnd_opnd(), rnd_opnd(), 1'b1);
    idle(1, 1'b1);

    // Shift amount uses only the low log2(WIDTH) bits; MUL wraps mod 2^W.
    cycle(1'b1, OP_SLL, 32'd1, 32'h0000_0025, 1'b1);
    check("sll_mask", bus.result, 32'd32);
    cycle(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1);
    for (int i = 0; i < MUL_LAT - 1; i++) cycle(1'b0, OP_ADD, '0, '0, 1'b1);
    check("mul_wrap", bus.result, 32'hFFFF_FFFE);
    idle(1, 1'b1);

    // Reset during a multiply discards it; the next op completes normally.
    cycle(1'b1, OP_MUL, 32'd77, 32'd99, 1'b1);
    idle(9, 1'b1);
    do_reset();
    cycle(1'b1, OP_ADD, 32'd3, 32'd4, 1'b1);
    check("post_rst_add", bus.result, 32'd7);
    idle(1, 1'b1);

    // Randomized traffic with random back-pressure and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
            $urandom_range(0, 9) < 7);
    end
    idle(MUL_LAT + 2, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
